// File: rtl/reg_bank.sv
// Register bank: eight general registers (r0 = accumulator) plus PC, OR-combined bus read path.
// Optional bus contention detector enabled by defining REG_BANK_CONTENTION_CHECK_EN.
module reg_bank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            reg_read_en,
  input  logic [7:0]            reg_write_en,
  input  logic                  reg_pc_read_en,
  input  logic                  reg_pc_write_en,
  input  logic                  pc_inc_en,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] bus_out,
  output logic                  bus_out_valid,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic                  contention_err,
  output logic [3:0]            err_count
);

  logic [DATA_WIDTH-1:0] regs_q [8];
  logic [DATA_WIDTH-1:0] regs_d [8];
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic [DATA_WIDTH-1:0] pc_as_data;
  logic [PC_WIDTH-1:0]   bus_as_pc;

  // PC <-> bus width adaptation: zero-pad upward, keep low bits downward.
  generate
    if (PC_WIDTH >= DATA_WIDTH) begin : g_pc_wide
      assign pc_as_data = pc_q[DATA_WIDTH-1:0];
      assign bus_as_pc  = {{(PC_WIDTH-DATA_WIDTH){1'b0}}, bus_in};
    end else begin : g_pc_narrow
      assign pc_as_data = {{(DATA_WIDTH-PC_WIDTH){1'b0}}, pc_q};
      assign bus_as_pc  = bus_in[PC_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    bus_out = '0;
    for (int n = 0; n < 8; n++) begin
      if (reg_read_en[n]) bus_out = bus_out | regs_q[n];
    end
    if (reg_pc_read_en) bus_out = bus_out | pc_as_data;
  end

  assign bus_out_valid = (|reg_read_en) | reg_pc_read_en;
  assign acc_out       = regs_q[0];
  assign pc_out        = pc_q;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      regs_d[n] = reg_write_en[n] ? bus_in : regs_q[n];
    end
    pc_d = pc_q;
    if (reg_pc_write_en) pc_d = bus_as_pc;
    else if (pc_inc_en)  pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 8; n++) regs_q[n] <= '0;
      pc_q <= PC_WIDTH'(RESET_PC);
    end else begin
      for (int n = 0; n < 8; n++) regs_q[n] <= regs_d[n];
      pc_q <= pc_d;
    end
  end

`ifdef REG_BANK_CONTENTION_CHECK_EN
  logic [8:0] src_en;
  logic       multi_src;
  logic       err_q;
  logic       err_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign src_en    = {reg_pc_read_en, reg_read_en};
  assign multi_src = |(src_en & (src_en - 9'd1));

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = 4'd0;
    end
    if (multi_src) begin
      err_d = 1'b1;
      if (cnt_d != 4'hF) cnt_d = cnt_d + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign contention_err = err_q;
  assign err_count      = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign contention_err = 1'b0;
  assign err_count      = 4'd0;
`endif

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank; expectations are queued when stimulus is driven and popped at sample time.
// Contention expectations follow REG_BANK_CONTENTION_CHECK_EN.
module tb_reg_bank;

`ifdef REG_BANK_CONTENTION_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] reg_read_en;
  logic [7:0] reg_write_en;
  logic       reg_pc_read_en;
  logic       reg_pc_write_en;
  logic       pc_inc_en;
  logic [7:0] bus_in;
  logic       err_clr;
  logic [7:0] bus_out;
  logic       bus_out_valid;
  logic [7:0] acc_out;
  logic [7:0] pc_out;
  logic       contention_err;
  logic [3:0] err_count;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  reg_bank #(.DATA_WIDTH(8), .PC_WIDTH(8), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .reg_read_en(reg_read_en), .reg_write_en(reg_write_en),
    .reg_pc_read_en(reg_pc_read_en), .reg_pc_write_en(reg_pc_write_en),
    .pc_inc_en(pc_inc_en), .bus_in(bus_in), .err_clr(err_clr),
    .bus_out(bus_out), .bus_out_valid(bus_out_valid), .acc_out(acc_out),
    .pc_out(pc_out), .contention_err(contention_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_read_en = 8'h00; reg_write_en = 8'h00; reg_pc_read_en = 1'b0;
    reg_pc_write_en = 1'b0; pc_inc_en = 1'b0; bus_in = 8'h00; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_write_en = 8'hFF; bus_in = 8'h77; pc_inc_en = 1'b1;
    reg_read_en = 8'h06;
    step();
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    exp_q.push_back('{"reset_pc", 8'h00});
    exp_q.push_back('{"reset_bus", 8'h00});
    exp_q.push_back('{"reset_valid", 8'h00});
    exp_q.push_back('{"reset_acc", 8'h00});
    exp_q.push_back('{"reset_err", 8'h00});
    exp_q.push_back('{"reset_cnt", 8'h00});
    e = exp_q.pop_front(); total++;
    if (pc_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, pc_out, e.val); end
    e = exp_q.pop_front(); total++;
    if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    e = exp_q.pop_front(); total++;
    if ({7'd0, bus_out_valid} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out_valid, e.val); end
    e = exp_q.pop_front(); total++;
    if (acc_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, acc_out, e.val); end
    e = exp_q.pop_front(); total++;
    if ({7'd0, contention_err} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, contention_err, e.val); end
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
    for (int n = 0; n < 8; n++) begin
      reg_read_en = 8'(1 << n);
      exp_q.push_back('{$sformatf("reset_r%0d", n), 8'h00});
      #1;
      e = exp_q.pop_front(); total++;
      if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    reg_write_en = 8'h08; bus_in = 8'hA5;
    step();
    reg_write_en = 8'h00; reg_read_en = 8'h08;
    #1;
    exp_q.push_back('{"r3_read", 8'hA5});
    exp_q.push_back('{"r3_valid", 8'h01});
    e = exp_q.pop_front(); total++;
    if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    e = exp_q.pop_front(); total++;
    if ({7'd0, bus_out_valid} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out_valid, e.val); end
    reg_write_en = 8'h08; bus_in = 8'h5A;
    #1;
    exp_q.push_back('{"r3_rw_old", 8'hA5});
    e = exp_q.pop_front(); total++;
    if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    step();
    reg_write_en = 8'h00;
    #1;
    exp_q.push_back('{"r3_rw_new", 8'h5A});
    e = exp_q.pop_front(); total++;
    if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    idle_inputs();
  endtask

  task automatic test_broadcast();
    reg_write_en = 8'hFF; bus_in = 8'h3C;
    step();
    idle_inputs();
    exp_q.push_back('{"bcast_acc", 8'h3C});
    e = exp_q.pop_front(); total++;
    if (acc_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, acc_out, e.val); end
    for (int n = 0; n < 8; n++) begin
      reg_read_en = 8'(1 << n);
      exp_q.push_back('{$sformatf("bcast_r%0d", n), 8'h3C});
      #1;
      e = exp_q.pop_front(); total++;
      if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    end
    idle_inputs();
  endtask

  task automatic test_pc();
    logic [7:0] seq [4];
    seq = '{8'hFF, 8'h00, 8'h40, 8'h41};
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      case (i)
        0: begin reg_pc_write_en = 1'b1; bus_in = 8'hFF; end
        1: pc_inc_en = 1'b1;
        2: begin reg_pc_write_en = 1'b1; pc_inc_en = 1'b1; bus_in = 8'h40; end
        default: pc_inc_en = 1'b1;
      endcase
      exp_q.push_back('{$sformatf("pc_step%0d", i), seq[i]});
      step();
      e = exp_q.pop_front(); total++;
      if (pc_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, pc_out, e.val); end
    end
    idle_inputs();
    reg_pc_read_en = 1'b1;
    #1;
    exp_q.push_back('{"pc_on_bus", 8'h41});
    exp_q.push_back('{"pc_valid", 8'h01});
    e = exp_q.pop_front(); total++;
    if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    e = exp_q.pop_front(); total++;
    if ({7'd0, bus_out_valid} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out_valid, e.val); end
    step();
    exp_q.push_back('{"pc_hold", 8'h41});
    e = exp_q.pop_front(); total++;
    if (pc_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, pc_out, e.val); end
    idle_inputs();
  endtask

  task automatic test_contention();
    reg_write_en = 8'h02; bus_in = 8'h0F;
    step();
    reg_write_en = 8'h04; bus_in = 8'hF0;
    step();
    idle_inputs();
    reg_read_en = 8'h06;
    #1;
    exp_q.push_back('{"cont_bus", 8'hFF});
    e = exp_q.pop_front(); total++;
    if (bus_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, bus_out, e.val); end
    exp_q.push_back('{"cont_err1", {7'd0, CHK}});
    exp_q.push_back('{"cont_cnt1", CHK ? 8'd1 : 8'd0});
    step();
    e = exp_q.pop_front(); total++;
    if ({7'd0, contention_err} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, contention_err, e.val); end
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
    exp_q.push_back('{"cont_sat", CHK ? 8'd15 : 8'd0});
    for (int i = 0; i < 19; i++) step();
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
    err_clr = 1'b1;
    exp_q.push_back('{"clr_cont_err", {7'd0, CHK}});
    exp_q.push_back('{"clr_cont_cnt", CHK ? 8'd1 : 8'd0});
    step();
    e = exp_q.pop_front(); total++;
    if ({7'd0, contention_err} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, contention_err, e.val); end
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
    reg_read_en = 8'h00;
    exp_q.push_back('{"clr_err", 8'h00});
    exp_q.push_back('{"clr_cnt", 8'h00});
    step();
    e = exp_q.pop_front(); total++;
    if ({7'd0, contention_err} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, contention_err, e.val); end
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
    err_clr = 1'b0;
    reg_read_en = 8'h01; reg_pc_read_en = 1'b1;
    exp_q.push_back('{"pc_cont_cnt", CHK ? 8'd1 : 8'd0});
    step();
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
    reg_pc_read_en = 1'b0;
    exp_q.push_back('{"single_src_cnt", CHK ? 8'd1 : 8'd0});
    exp_q.push_back('{"single_src_err", {7'd0, CHK}});
    step();
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
    e = exp_q.pop_front(); total++;
    if ({7'd0, contention_err} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, contention_err, e.val); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    pc_inc_en = 1'b1; reg_write_en = 8'h01; bus_in = 8'h99; reg_read_en = 8'h06;
    rst = 1'b1;
    exp_q.push_back('{"midrst_pc", 8'h00});
    exp_q.push_back('{"midrst_acc", 8'h00});
    exp_q.push_back('{"midrst_cnt", 8'h00});
    step();
    rst = 1'b0;
    idle_inputs();
    e = exp_q.pop_front(); total++;
    if (pc_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, pc_out, e.val); end
    e = exp_q.pop_front(); total++;
    if (acc_out !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, acc_out, e.val); end
    e = exp_q.pop_front(); total++;
    if ({4'd0, err_count} !== e.val) begin bad++; $display("[TB] FAIL %s got=%h want=%h", e.name, err_count, e.val); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_broadcast();
    test_pc();
    test_contention();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
